// File: rtl/hsc_tdc_top.sv
`default_nettype none
// ============================================================================
// Module      : hsc_tdc_top
// Description : Delay-line time-to-digital converter core. A launch level
//               runs through an N-stage delay line. The taps are captured as
//               a thermometer code, passed through N_SYNC synchronizer
//               stages and reduced to a Hamming weight with a valid tag.
// Revision    : 1.0 - initial release
// ============================================================================
module hsc_tdc_top #(
  parameter int    N          = 64,
  parameter string DL_TYPE    = "DBUF",
  parameter int    N_SYNC     = 1,
  parameter string POP_METHOD = "SV"
) (
  input  logic                 clk_capture,
  input  logic                 rst,
  input  logic                 clk_launch,
  input  logic                 en,
  input  logic                 val_in,
  input  logic                 pg_src,
  input  logic                 pg_bypass,
  input  logic                 pg_in,
  input  logic                 pg_tog,
  output logic [$clog2(N):0]   hw,
  output logic                 val_out
);

  localparam int C_LOG2N = $clog2(N);
  localparam int C_CW    = C_LOG2N + 1;

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  if ((N < 4) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("hsc_tdc_top: N must be a power of two and at least 4");
  end

  if ((N_SYNC < 0) || (N_SYNC > 4)) begin : g_bad_sync
    $error("hsc_tdc_top: N_SYNC must be in the range 0..4");
  end

  if ((DL_TYPE != "DBUF") && (DL_TYPE != "INV")) begin : g_bad_dl
    $error("hsc_tdc_top: DL_TYPE must be \"DBUF\" or \"INV\"");
  end

  if ((POP_METHOD != "SV") && (POP_METHOD != "TREE")) begin : g_bad_pop
    $error("hsc_tdc_top: POP_METHOD must be \"SV\" or \"TREE\"");
  end

  // --------------------------------------------------------------------------
  // Pulse generator
  // --------------------------------------------------------------------------
  logic r_tog_q;
  logic w_src;
  logic w_pg_out;
  logic w_dl_in;

  // Free-running toggle source: flips on every enabled capture cycle.
  always_ff @(posedge clk_capture) begin
    if (rst) begin
      r_tog_q <= 1'b0;
    end else if (en) begin
      r_tog_q <= ~r_tog_q;
    end
  end

  // clk_launch is treated purely as a data level here, never as a clock.
  assign w_src    = pg_src ? pg_in : clk_launch;
  assign w_pg_out = pg_tog ? r_tog_q : w_src;
  assign w_dl_in  = pg_bypass ? pg_in : w_pg_out;

  // --------------------------------------------------------------------------
  // Delay line
  // --------------------------------------------------------------------------
  logic [N-1:0] w_taps;

  for (genvar i = 0; i < N; i++) begin : g_cell
    logic w_cell_in;
    (* keep = "true", dont_touch = "true" *) logic w_cell_out;

    if (i == 0) begin : g_head
      assign w_cell_in = w_dl_in;
    end else begin : g_body
      assign w_cell_in = g_cell[i-1].w_cell_out;
    end

    if (DL_TYPE == "INV") begin : g_inv
      assign w_cell_out = ~w_cell_in;
      // Tap i sits behind i+1 inversions, so the taps with an odd count of
      // inversions (even index) are flipped back to the launch polarity.
      if ((i % 2) == 0) begin : g_fix
        assign w_taps[i] = ~w_cell_out;
      end else begin : g_pass
        assign w_taps[i] = w_cell_out;
      end
    end else begin : g_buf
      assign w_cell_out = w_cell_in;
      assign w_taps[i]  = w_cell_out;
    end
  end

  // --------------------------------------------------------------------------
  // Capture and synchronizer stages (stage 0 is the capture register)
  // --------------------------------------------------------------------------
  logic [N-1:0]  r_stage_data [N_SYNC+1];
  logic [N_SYNC:0] r_stage_v;
  logic [N-1:0]  w_last;
  logic          w_last_v;

  // Shift the tap snapshot and its valid tag down the synchronizer chain.
  always_ff @(posedge clk_capture) begin
    if (rst) begin
      for (int k = 0; k <= N_SYNC; k++) begin
        r_stage_data[k] <= '0;
      end
      r_stage_v <= '0;
    end else if (en) begin
      r_stage_data[0] <= w_taps;
      r_stage_v[0]    <= val_in;
      for (int k = 1; k <= N_SYNC; k++) begin
        r_stage_data[k] <= r_stage_data[k-1];
        r_stage_v[k]    <= r_stage_v[k-1];
      end
    end
  end

  assign w_last   = r_stage_data[N_SYNC];
  assign w_last_v = r_stage_v[N_SYNC];

  // --------------------------------------------------------------------------
  // Population count (bubbles counted as-is)
  // --------------------------------------------------------------------------
  logic [C_CW-1:0] w_pop;

  if (POP_METHOD == "TREE") begin : g_pop_tree
    // Level l holds N>>l partial sums, each l+1 bits wide.
    for (genvar l = 0; l <= C_LOG2N; l++) begin : g_lvl
      logic [l:0] w_sum [N>>l];
      if (l == 0) begin : g_leaf
        for (genvar j = 0; j < N; j++) begin : g_node
          assign w_sum[j] = w_last[j];
        end
      end else begin : g_add
        for (genvar j = 0; j < (N >> l); j++) begin : g_node
          assign w_sum[j] = {1'b0, g_lvl[l-1].w_sum[2*j]}
                          + {1'b0, g_lvl[l-1].w_sum[2*j+1]};
        end
      end
    end
    assign w_pop = g_lvl[C_LOG2N].w_sum[0];
  end else begin : g_pop_sv
    // Behavioural ones-count over the last synchronizer stage.
    always_comb begin
      w_pop = '0;
      for (int k = 0; k < N; k++) begin
        w_pop = w_pop + {{C_LOG2N{1'b0}}, w_last[k]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  // Register the count and its valid tag for the I/O wrapper.
  always_ff @(posedge clk_capture) begin
    if (rst) begin
      hw      <= '0;
      val_out <= 1'b0;
    end else if (en) begin
      hw      <= w_pop;
      val_out <= w_last_v;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hsc_tdc_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsc_tdc_top
// Description : Directed self-checking bench for hsc_tdc_top. Four instances
//               with different N / DL_TYPE / N_SYNC / POP_METHOD share the
//               same stimulus; each is checked against its own latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsc_tdc_top;

  logic clk_capture = 1'b0;
  logic rst         = 1'b1;
  logic clk_launch  = 1'b0;
  logic en          = 1'b1;
  logic val_in      = 1'b1;
  logic pg_src      = 1'b0;
  logic pg_bypass   = 1'b1;
  logic pg_in       = 1'b1;
  logic pg_tog      = 1'b0;

  logic [6:0] hw0, hw1;
  logic [3:0] hw2, hw3;
  logic       v0, v1, v2, v3;

  int tests  = 0;
  int failed = 0;

  // Per-instance full-scale count and latency (N_SYNC + 2).
  int c_n   [4] = '{64, 64, 8, 8};
  int c_lat [4] = '{3, 3, 2, 4};

  always #5 clk_capture = ~clk_capture;

  // Default configuration: N=64, DBUF, N_SYNC=1, SV.
  hsc_tdc_top dut0 (
    .clk_capture(clk_capture), .rst(rst), .clk_launch(clk_launch), .en(en),
    .val_in(val_in), .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in),
    .pg_tog(pg_tog), .hw(hw0), .val_out(v0)
  );

  hsc_tdc_top #(.N(64), .DL_TYPE("INV"), .N_SYNC(1), .POP_METHOD("TREE")) dut1 (
    .clk_capture(clk_capture), .rst(rst), .clk_launch(clk_launch), .en(en),
    .val_in(val_in), .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in),
    .pg_tog(pg_tog), .hw(hw1), .val_out(v1)
  );

  hsc_tdc_top #(.N(8), .DL_TYPE("INV"), .N_SYNC(0), .POP_METHOD("TREE")) dut2 (
    .clk_capture(clk_capture), .rst(rst), .clk_launch(clk_launch), .en(en),
    .val_in(val_in), .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in),
    .pg_tog(pg_tog), .hw(hw2), .val_out(v2)
  );

  hsc_tdc_top #(.N(8), .DL_TYPE("DBUF"), .N_SYNC(2), .POP_METHOD("SV")) dut3 (
    .clk_capture(clk_capture), .rst(rst), .clk_launch(clk_launch), .en(en),
    .val_in(val_in), .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in),
    .pg_tog(pg_tog), .hw(hw3), .val_out(v3)
  );

  function automatic logic [6:0] hw_of(input int d);
    case (d)
      0:       hw_of = hw0;
      1:       hw_of = hw1;
      2:       hw_of = {3'b000, hw2};
      default: hw_of = {3'b000, hw3};
    endcase
  endfunction

  function automatic logic val_of(input int d);
    case (d)
      0:       val_of = v0;
      1:       val_of = v1;
      2:       val_of = v2;
      default: val_of = v3;
    endcase
  endfunction

  // Advance one capture edge and settle just after it.
  task automatic step();
    @(posedge clk_capture);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exp_hw;
    logic       exp_v;
    rst = 1'b1; en = 1'b1; val_in = 1'b1;
    pg_bypass = 1'b1; pg_in = 1'b1; pg_tog = 1'b0; pg_src = 1'b0;
    repeat (3) step();
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (hw_of(d) !== 7'd0 || val_of(d) !== 1'b0) begin
        failed++;
        $display("FAIL reset_state dut%0d: hw=%0d val=%b, want hw=0 val=0", d, hw_of(d), val_of(d));
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        exp_v  = (k >= c_lat[d]);
        exp_hw = exp_v ? 7'(c_n[d]) : 7'd0;
        tests++;
        if (hw_of(d) !== exp_hw || val_of(d) !== exp_v) begin
          failed++;
          $display("FAIL reset_release dut%0d k=%0d: hw=%0d val=%b, want hw=%0d val=%b",
                   d, k, hw_of(d), val_of(d), exp_hw, exp_v);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [6:0] exp_hw;
    pg_bypass = 1'b1; pg_in = 1'b0; val_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        exp_hw = (k >= c_lat[d]) ? 7'd0 : 7'(c_n[d]);
        tests++;
        if (hw_of(d) !== exp_hw || val_of(d) !== 1'b1) begin
          failed++;
          $display("FAIL bypass_low dut%0d k=%0d: hw=%0d val=%b, want hw=%0d val=1",
                   d, k, hw_of(d), val_of(d), exp_hw);
        end
      end
    end
  endtask

  task automatic test_source_select();
    logic [6:0] exp_hw;
    pg_bypass = 1'b0; pg_tog = 1'b0; pg_src = 1'b0; clk_launch = 1'b1; pg_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        exp_hw = (k >= c_lat[d]) ? 7'(c_n[d]) : 7'd0;
        tests++;
        if (hw_of(d) !== exp_hw) begin
          failed++;
          $display("FAIL src_launch dut%0d k=%0d: hw=%0d, want %0d", d, k, hw_of(d), exp_hw);
        end
      end
    end
    pg_src = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        exp_hw = (k >= c_lat[d]) ? 7'd0 : 7'(c_n[d]);
        tests++;
        if (hw_of(d) !== exp_hw) begin
          failed++;
          $display("FAIL src_pg_in dut%0d k=%0d: hw=%0d, want %0d", d, k, hw_of(d), exp_hw);
        end
      end
    end
  endtask

  task automatic test_toggle();
    logic [6:0] exp_hw;
    logic       exp_v;
    pg_tog = 1'b1; pg_bypass = 1'b0; val_in = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    // Capture edge m samples tog_q = (m-1) mod 2, starting from the reset 0.
    for (int k = 1; k <= 7; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        exp_v  = (k >= c_lat[d]);
        exp_hw = (exp_v && (((k - c_lat[d]) % 2) == 1)) ? 7'(c_n[d]) : 7'd0;
        tests++;
        if (hw_of(d) !== exp_hw || val_of(d) !== exp_v) begin
          failed++;
          $display("FAIL toggle dut%0d k=%0d: hw=%0d val=%b, want hw=%0d val=%b",
                   d, k, hw_of(d), val_of(d), exp_hw, exp_v);
        end
      end
    end
    pg_tog = 1'b0;
  endtask

  task automatic test_enable_stall();
    logic [6:0] exp_hw;
    pg_bypass = 1'b1; pg_in = 1'b1; val_in = 1'b1; en = 1'b1;
    repeat (4) step();
    en = 1'b0; pg_in = 1'b0; val_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        tests++;
        if (hw_of(d) !== 7'(c_n[d]) || val_of(d) !== 1'b1) begin
          failed++;
          $display("FAIL stall_hold dut%0d k=%0d: hw=%0d val=%b, want hw=%0d val=1",
                   d, k, hw_of(d), val_of(d), c_n[d]);
        end
      end
    end
    en = 1'b1; val_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        exp_hw = (k >= c_lat[d]) ? 7'd0 : 7'(c_n[d]);
        tests++;
        if (hw_of(d) !== exp_hw || val_of(d) !== 1'b1) begin
          failed++;
          $display("FAIL stall_resume dut%0d k=%0d: hw=%0d val=%b, want hw=%0d val=1",
                   d, k, hw_of(d), val_of(d), exp_hw);
        end
      end
    end
  endtask

  task automatic test_valid_drop();
    logic exp_v;
    pg_bypass = 1'b1; pg_in = 1'b1; val_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      for (int d = 0; d < 4; d++) begin
        exp_v = (k < c_lat[d]);
        tests++;
        if (val_of(d) !== exp_v) begin
          failed++;
          $display("FAIL valid_drop dut%0d k=%0d: val=%b, want %b", d, k, val_of(d), exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_source_select();
    test_toggle();
    test_enable_stall();
    test_valid_drop();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
